// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer: FSM state
// encoding and the bit-counter width helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } state_t;

  // Wide enough to hold the values 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts bits accepted in the current frame; flags the last bit position so
// the FSM knows the next accepted bit completes the word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         present,
  input  logic                         inc,
  input  logic                         clear,
  output logic [cnt_width(WIDTH)-1:0]  cnt,
  output logic                         last
);

  localparam int CW = cnt_width(WIDTH);

  // clear together with inc means the accepted bit opens a fresh frame.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (!present) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a valid/ready word output, a sticky
// overrun flag and the storage-cell style clear/preset control pair.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         present,
  input  logic                         d_in,
  input  logic                         d_valid,
  input  logic                         q_ready,
  output logic [WIDTH-1:0]             q_par,
  output logic                         q_valid,
  output logic                         busy,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         overrun
);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   shifted;
  logic               do_shift;
  logic               load;
  logic               set_ovr;
  logic               cnt_inc;
  logic               cnt_clear;
  logic               last;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {sr[WIDTH-2:0], d_in};
  end else begin : g_lsb_first
    assign shifted = {d_in, sr[WIDTH-1:1]};
  end

  sipo_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk     (clk),
    .clr     (clr),
    .present (present),
    .inc     (cnt_inc),
    .clear   (cnt_clear),
    .cnt     (bit_cnt),
    .last    (last)
  );

  always_comb begin
    next_state = state;
    do_shift   = 1'b0;
    load       = 1'b0;
    set_ovr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (d_valid) begin
          do_shift   = 1'b1;
          cnt_inc    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (d_valid) begin
          do_shift = 1'b1;
          if (last) begin
            load       = 1'b1;
            cnt_clear  = 1'b1;
            next_state = FULL;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FULL: begin
        if (q_ready) begin
          if (d_valid) begin
            do_shift   = 1'b1;
            cnt_inc    = 1'b1;
            next_state = SHIFT;
          end else begin
            next_state = IDLE;
          end
        end else if (d_valid) begin
          set_ovr = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // q_valid and busy are registered copies of the next state, so no output
  // depends combinationally on an input.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      sr      <= '0;
      q_par   <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else if (!present) begin
      state   <= IDLE;
      sr      <= '1;
      q_par   <= '1;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= next_state;
      q_valid <= (next_state == FULL);
      busy    <= (next_state == SHIFT);
      if (do_shift) sr <= shifted;
      if (load) q_par <= shifted;
      if (set_ovr) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Randomized scoreboard bench for sipo_deser: an MSB-first and an LSB-first
// instance share stimulus and are checked against a bit-queue reference model.
module tb_sipo_deser;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             present;
  logic             d_in;
  logic             d_valid;
  logic             q_ready;
  logic [WIDTH-1:0] par_m;
  logic [WIDTH-1:0] par_l;
  logic             valid_m;
  logic             valid_l;
  logic             busy_m;
  logic             busy_l;
  logic [CW-1:0]    cnt_m;
  logic [CW-1:0]    cnt_l;
  logic             ovr_m;
  logic             ovr_l;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic             bit_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_q_lsb[$];
  logic             held = 1'b0;
  logic             ovr  = 1'b0;
  logic [WIDTH-1:0] exp_par     = '0;
  logic [WIDTH-1:0] exp_par_lsb = '0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .clr(clr), .present(present), .d_in(d_in), .d_valid(d_valid),
    .q_ready(q_ready), .q_par(par_m), .q_valid(valid_m), .busy(busy_m),
    .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .present(present), .d_in(d_in), .d_valid(d_valid),
    .q_ready(q_ready), .q_par(par_l), .q_valid(valid_l), .busy(busy_l),
    .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Word transfers happen at the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    if (clr && present && valid_m && q_ready) begin
      if (exp_q.size() == 0) checkOutput("sb_underflow_msb", 1, 0);
      else checkOutput("sb_word_msb", par_m, exp_q.pop_front());
    end
    if (clr && present && valid_l && q_ready) begin
      if (exp_q_lsb.size() == 0) checkOutput("sb_underflow_lsb", 1, 0);
      else checkOutput("sb_word_lsb", par_l, exp_q_lsb.pop_front());
    end
  end

  task automatic modelDiscard(input logic [WIDTH-1:0] fill);
    if (held) begin
      void'(exp_q.pop_back());
      void'(exp_q_lsb.pop_back());
    end
    bit_q.delete();
    held        = 1'b0;
    ovr         = 1'b0;
    exp_par     = fill;
    exp_par_lsb = fill;
  endtask

  task automatic modelEdge();
    logic accept;
    int   wm;
    int   wl;
    if (!present) begin
      modelDiscard('1);
    end else begin
      accept = d_valid && (!held || q_ready);
      if (held && !q_ready && d_valid) ovr = 1'b1;
      if (held && q_ready) held = 1'b0;
      if (accept) begin
        bit_q.push_back(d_in);
        if (bit_q.size() == WIDTH) begin
          wm = 0;
          wl = 0;
          for (int i = 0; i < WIDTH; i++) begin
            wm += int'(bit_q[i]) * (1 << (WIDTH - 1 - i));
            wl += int'(bit_q[i]) * (1 << i);
          end
          exp_par     = wm[WIDTH-1:0];
          exp_par_lsb = wl[WIDTH-1:0];
          exp_q.push_back(exp_par);
          exp_q_lsb.push_back(exp_par_lsb);
          bit_q.delete();
          held = 1'b1;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("bit_cnt", cnt_m, bit_q.size());
    checkOutput("q_valid", valid_m, held);
    checkOutput("busy", busy_m, bit_q.size() != 0);
    checkOutput("overrun", ovr_m, ovr);
    checkOutput("q_par", par_m, exp_par);
    checkOutput("lsb_bit_cnt", cnt_l, bit_q.size());
    checkOutput("lsb_q_valid", valid_l, held);
    checkOutput("lsb_overrun", ovr_l, ovr);
    checkOutput("lsb_q_par", par_l, exp_par_lsb);
  endtask

  // Called at posedge+2; inputs stay stable until posedge+2 of the next cycle.
  task automatic applyStimulus(input logic pr, input logic dv, input logic di,
                               input logic qr);
    present = pr;
    d_valid = dv;
    d_in    = di;
    q_ready = qr;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
    #1;
  endtask

  task automatic sendByte(input logic [WIDTH-1:0] b, input logic qr, input int gap);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, b[i], qr);
      if (i != 0) for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b0, 1'b0, qr);
    end
  endtask

  task automatic resetAsync();
    clr = 1'b0;
    #1;
    modelDiscard('0);
    checkOutput("clr_q_par", par_m, 0);
    checkOutput("clr_q_valid", valid_m, 0);
    checkOutput("clr_busy", busy_m, 0);
    checkOutput("clr_bit_cnt", cnt_m, 0);
    checkOutput("clr_overrun", ovr_m, 0);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clr     = 1'b0;
    present = 1'b1;
    d_in    = 1'b0;
    d_valid = 1'b0;
    q_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset_q_par", par_m, 0);
    checkOutput("reset_q_valid", valid_m, 0);
    checkOutput("reset_bit_cnt", cnt_m, 0);
    clr = 1'b1;

    // Single frame with a one-cycle valid pulse.
    sendByte(8'hB2, 1'b1, 0);
    checkOutput("single_word", par_m, 8'hB2);
    checkOutput("single_valid", valid_m, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("single_pulse_end", valid_m, 0);

    // Back-pressure: extra bits are dropped while the word is held.
    sendByte(8'hB2, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_word_held", par_m, 8'hB2);
    checkOutput("bp_valid_held", valid_m, 1);
    checkOutput("bp_overrun", ovr_m, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_release_valid", valid_m, 0);
    checkOutput("bp_overrun_sticky", ovr_m, 1);

    // Back-to-back words, no bubble.
    sendByte(8'hA5, 1'b1, 0);
    sendByte(8'h3C, 1'b1, 0);
    checkOutput("b2b_second", par_m, 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Preset aborts a partial frame.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("preset_q_par", par_m, 8'hFF);
    checkOutput("preset_bit_cnt", cnt_m, 0);
    checkOutput("preset_overrun", ovr_m, 0);
    sendByte(8'h0F, 1'b1, 0);
    checkOutput("after_preset_word", par_m, 8'h0F);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous clear mid-frame.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    resetAsync();

    // First bit 1, rest 0: LSB-first instance sees 8'h01, with and without gaps.
    sendByte(8'h80, 1'b1, 0);
    checkOutput("lsb_word", par_l, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    sendByte(8'h80, 1'b1, 2);
    checkOutput("lsb_word_gaps", par_l, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(39) != 0, $urandom_range(9) < 7,
                    1'($urandom), $urandom_range(9) < 6);
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("sb_drain_msb", exp_q.size(), 0);
    checkOutput("sb_drain_lsb", exp_q_lsb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
